// File: rtl/sw_host_driver.sv
// Host-side switch/LED stimulus engine for a picoMIPS processor: queues operand
// bytes, resets the processor, hands words over on SW with timed phases, captures LED.
module sw_host_driver #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned LOW_CYCLES  = 16,
  parameter int unsigned RESULT_WAIT = 64
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [7:0] InData,
  input  logic       InValid,
  output logic       InReady,
  input  logic       Start,
  output logic       Busy,
  output logic [9:0] SW,
  input  logic [7:0] LED,
  output logic [7:0] Result,
  output logic       ResultValid
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned MAX1 = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX2 = (LOW_CYCLES > RESULT_WAIT) ? LOW_CYCLES : RESULT_WAIT;
  localparam int unsigned MAXP = (MAX1 > MAX2) ? MAX1 : MAX2;
  localparam int unsigned CW   = $clog2(MAXP + 1);

  typedef enum logic [2:0] {IDLE, CPU_RST, HS_LOW, HS_HIGH, WAIT_RES} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          expire;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_d;
  logic          push, pop, empty;

  logic [9:0]    sw_d;
  logic          busy_d, rv_d;
  logic [7:0]    result_d;

  assign push   = InValid && InReady;
  assign empty  = (count == '0);
  assign expire = (cnt == '0);

  function automatic logic [CW-1:0] phase_len(input state_t s);
    case (s)
      CPU_RST:  phase_len = CW'(RST_CYCLES - 1);
      HS_LOW:   phase_len = CW'(LOW_CYCLES - 1);
      HS_HIGH:  phase_len = CW'(HOLD_CYCLES - 1);
      WAIT_RES: phase_len = CW'(RESULT_WAIT - 1);
      default:  phase_len = '0;
    endcase
  endfunction

  // State, phase counter and all registered outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      cnt         <= '0;
      SW          <= '0;
      Busy        <= 1'b0;
      Result      <= '0;
      ResultValid <= 1'b0;
      InReady     <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      SW          <= sw_d;
      Busy        <= busy_d;
      Result      <= result_d;
      ResultValid <= rv_d;
      InReady     <= (state_d == IDLE) && (count_d != (AW+1)'(DEPTH));
    end
  end

  // Next state; the shared phase counter reloads on every state change.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (Start) state_d = CPU_RST;
      CPU_RST:  if (expire) state_d = HS_LOW;
      HS_LOW:   if (expire) state_d = empty ? WAIT_RES : HS_HIGH;
      HS_HIGH:  if (expire) state_d = HS_LOW;
      WAIT_RES: if (expire) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (state_d != state) cnt_d = phase_len(state_d);
    else if (!expire)     cnt_d = cnt - CW'(1);
    else                  cnt_d = cnt;
  end

  // Next values of the registered outputs and the FIFO pop.
  always_comb begin
    sw_d     = SW;
    busy_d   = Busy;
    rv_d     = ResultValid;
    result_d = Result;
    pop      = 1'b0;
    case (state)
      IDLE: if (Start) begin
        sw_d   = '0;
        busy_d = 1'b1;
        rv_d   = 1'b0;
      end
      CPU_RST: if (expire) sw_d[9] = 1'b1;
      HS_LOW: if (expire && !empty) begin
        pop          = 1'b1;
        sw_d[8]      = 1'b1;
        sw_d[7:0]    = mem[rd_ptr];
      end
      HS_HIGH: if (expire) sw_d[8] = 1'b0;
      WAIT_RES: if (expire) begin
        result_d = LED;
        rv_d     = 1'b1;
        busy_d   = 1'b0;
      end
      default: ;
    endcase
  end

  assign count_d = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= InData;
  end

endmodule

// File: tb/tb_sw_host_driver.sv
// Randomized bench for sw_host_driver: every cycle of a run is compared against
// a timeline computed from the handshake schedule formulas.
module tb_sw_host_driver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RST   = 4;
  localparam int unsigned HOLD  = 16;
  localparam int unsigned LOW   = 16;
  localparam int unsigned RW    = 64;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] InData = '0;
  logic       InValid = 1'b0;
  logic       InReady;
  logic       Start = 1'b0;
  logic       Busy;
  logic [9:0] SW;
  logic [7:0] LED = '0;
  logic [7:0] Result;
  logic       ResultValid;

  int unsigned total = 0;
  int unsigned bad = 0;
  byte unsigned fifo_q[$];

  sw_host_driver #(
    .DEPTH(DEPTH), .RST_CYCLES(RST), .HOLD_CYCLES(HOLD),
    .LOW_CYCLES(LOW), .RESULT_WAIT(RW)
  ) dut (
    .Clock(Clock), .nReset(nReset), .InData(InData), .InValid(InValid),
    .InReady(InReady), .Start(Start), .Busy(Busy), .SW(SW), .LED(LED),
    .Result(Result), .ResultValid(ResultValid)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {Busy, SW} at cycle c of a run carrying words w, finishing at cycle td.
  function automatic logic [10:0] model_bsw(input int c, input int td, input byte unsigned w[$]);
    int n, t, k, r, m;
    logic [7:0] d;
    n = w.size();
    if (c >= td) begin
      d = (n > 0) ? w[n-1] : 8'h00;
      return {1'b0, 1'b1, 1'b0, d};
    end
    if (c <= int'(RST)) return {1'b1, 10'h000};
    t = c - int'(RST) - 1;
    k = t / int'(LOW + HOLD);
    r = t % int'(LOW + HOLD);
    if (k < n && r >= int'(LOW)) return {1'b1, 1'b1, 1'b1, w[k]};
    m = (k < n) ? k : n;
    d = (m > 0) ? w[m-1] : 8'h00;
    return {1'b1, 1'b1, 1'b0, d};
  endfunction

  task automatic push_byte(input byte unsigned b);
    bit acc;
    acc = (fifo_q.size() < DEPTH);
    InData = b;
    InValid = 1'b1;
    check_eq("in_ready_push", InReady, acc);
    @(posedge Clock); #1;
    InValid = 1'b0;
    if (acc) fifo_q.push_back(b);
  endtask

  task automatic run(input int extra_start_at, input int push_busy_at, input int abort_at,
                     input bit push_now, input byte unsigned pb);
    byte unsigned w[$];
    logic [7:0] led_hist [0:511];
    int td;
    if (push_now) begin
      InData = pb;
      InValid = 1'b1;
      check_eq("in_ready_start", InReady, fifo_q.size() < DEPTH);
      if (fifo_q.size() < DEPTH) fifo_q.push_back(pb);
    end
    w = fifo_q;
    fifo_q.delete();
    td = int'(RST + LOW + RW) + w.size() * int'(HOLD + LOW) + 1;
    Start = 1'b1;
    for (int c = 1; c <= td + 2; c++) begin
      @(posedge Clock); #1;
      Start = 1'b0;
      InValid = 1'b0;
      check_eq("busy_sw", {Busy, SW}, model_bsw(c, td, w));
      check_eq("in_ready", InReady, c >= td);
      check_eq("result_valid", ResultValid, c >= td);
      if (c >= td) check_eq("result", Result, led_hist[td-1]);
      if (c == extra_start_at - 1) Start = 1'b1;
      if (c == push_busy_at - 1) begin
        InData = 8'($urandom);
        InValid = 1'b1;
      end
      if (c == abort_at) begin
        #1 nReset = 1'b0;
        #1;
        check_eq("abort_sw", SW, 10'h000);
        check_eq("abort_busy", Busy, 1'b0);
        check_eq("abort_rv", ResultValid, 1'b0);
        check_eq("abort_ready", InReady, 1'b1);
        #1 nReset = 1'b1;
        return;
      end
      LED = 8'($urandom);
      led_hist[c] = LED;
    end
  endtask

  initial begin
    #12;
    check_eq("rst_sw", SW, 10'h000);
    check_eq("rst_busy", Busy, 1'b0);
    check_eq("rst_result", Result, 8'h00);
    check_eq("rst_rv", ResultValid, 1'b0);
    check_eq("rst_ready", InReady, 1'b1);
    #1 nReset = 1'b1;
    @(posedge Clock); #1;

    push_byte(8'h05);
    push_byte(8'hFA);
    run(0, 0, 0, 1'b0, 8'h00);

    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    run(0, 0, 0, 1'b0, 8'h00);

    run(0, 0, 0, 1'b0, 8'h00);

    push_byte(8'($urandom));
    push_byte(8'($urandom));
    run(40, 50, 0, 1'b0, 8'h00);
    run(0, 0, 0, 1'b0, 8'h00);

    push_byte(8'($urandom));
    push_byte(8'($urandom));
    run(0, 0, 30, 1'b0, 8'h00);
    run(0, 0, 0, 1'b0, 8'h00);

    run(0, 0, 0, 1'b1, 8'h33);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(0, DEPTH + 1);
      for (int i = 0; i < n; i++) push_byte(8'($urandom));
      run(0, 0, 0, r[0], 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_host_driver.md
# sw_host_driver

Host-side stimulus engine for the switch/LED handshake of the picoMIPS top level: it drives the processor's 10-bit switch bus and samples its 8-bit LED bus. It buffers a short list of operand bytes and restarts the processor through its reset switch. It then hands the bytes over one at a time on the data/handshake switches with fixed high/low phases, and captures the LED value after a settling window. It sits in the FPGA test harness in place of the physical switches, one instance per processor.

## Interface

Parameters:
- DEPTH, 4: operand FIFO entries, power of two, 2..16.
- RST_CYCLES, 4: cycles the processor reset switch is held low per run, ≥1.
- HOLD_CYCLES, 16: cycles the handshake switch is held high per word, ≥1.
- LOW_CYCLES, 16: cycles the handshake switch is held low after reset release and after each word, ≥1.
- RESULT_WAIT, 64: cycles from the last low phase to result capture, ≥1.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- InData  in  8  operand byte to queue.
- InValid  in  1  InData valid.
- InReady  out  1  queue accepts InData this cycle.
- Start  in  1  single-cycle run request.
- Busy  out  1  run in progress.
- SW  out  10  to the processor: [9] processor nReset, [8] handshake, [7:0] data.
- LED  in  8  processor accumulator output.
- Result  out  8  captured LED value.
- ResultValid  out  1  Result holds the capture of the most recent run.

## Operation

- All outputs are registered. Reset values: SW=10'h000, so the processor is held in reset; Result=0, ResultValid=0, Busy=0, InReady=1. Reset empties the FIFO and forces IDLE from any state, mid-run included.
- FIFO: push when InValid && InReady. InReady = (state==IDLE) && !full. Push attempts while full or busy are dropped. There is no overflow flag.
- States: IDLE, CPU_RST, HS_LOW, HS_HIGH, WAIT_RES.
- IDLE: Busy=0. A Start sampled high moves to CPU_RST, sets Busy=1 and clears ResultValid. A push in the same cycle as Start is included in the run. Start outside IDLE is ignored.
- CPU_RST: SW=10'h000 for exactly RST_CYCLES cycles, then SW[9]=1 and move to HS_LOW.
- HS_LOW: SW[8]=0 for LOW_CYCLES cycles. SW[7:0] keeps the last word driven, or 0 if none has been driven this run. On expiry:
  - FIFO non-empty: pop, drive the popped byte on SW[7:0], go to HS_HIGH.
  - FIFO empty: go to WAIT_RES.
- HS_HIGH: SW[8]=1 with SW[7:0] stable for HOLD_CYCLES cycles, then HS_LOW. Data never changes while SW[8]=1.
- WAIT_RES: count RESULT_WAIT cycles. At expiry, Result<=LED, ResultValid<=1, Busy<=0, go to IDLE.
- After a run, SW[9] stays 1 and SW[7:0] keeps its last value until the next Start, so the LEDs stay live. ResultValid stays set until the next Start.
- One phase counter is shared by all timed states. It reloads on every state entry and is wide enough for the largest parameter.
- Empty FIFO at Start is legal: the run is a processor reset plus the result wait.

## Timing

- Cycle 0 is the edge that samples Start. Busy=1 from cycle 1.
- SW[9]=0 for cycles 1..RST_CYCLES.
- Word k (k=0..N-1) has SW[8]=1 for cycles RST_CYCLES+LOW_CYCLES+k·(HOLD_CYCLES+LOW_CYCLES)+1 through that value + HOLD_CYCLES − 1.
- ResultValid rises, and Busy falls, at cycle RST_CYCLES+LOW_CYCLES+N·(HOLD_CYCLES+LOW_CYCLES)+RESULT_WAIT+1.
- With defaults: N=0 gives cycle 85, N=1 gives cycle 117, N=4 gives cycle 213.
- Result is LED as sampled on the clock edge before ResultValid rises. LED is treated as synchronous to Clock.
- InReady returns to 1 in the same cycle Busy falls, if the FIFO is not full.

## Test plan

- Reset, then push 8'h05 and 8'hFA, then Start (defaults) -> SW[9] low for cycles 1..4. SW[8] high for cycles 21..36 with SW[7:0]=8'h05, and for 53..68 with SW[7:0]=8'hFA. ResultValid at cycle 149 with Result equal to LED at cycle 148.
- Push 5 bytes with DEPTH=4 -> the 5th is not accepted (InReady=0 while full). Run issues exactly 4 handshakes, in push order.
- Start with an empty FIFO -> no SW[8] pulse. ResultValid at cycle 85.
- Pulse Start again at cycle 40 of a running run -> ignored. Timing is identical to an undisturbed run.
- Assert nReset at cycle 30 of a 2-word run -> SW=10'h000, Busy=0, ResultValid=0, InReady=1 with no clock edge. After release, a Start with an empty FIFO performs no handshake.
- Push 8'h33 and Start in the same cycle -> 8'h33 is handshaked in the run. InReady=0 from cycle 1 until Busy falls.
